// File: rtl/cd_tx_pages_ctrl.sv
// rtl/cd_tx_pages_ctrl.sv - CDBUS tx page scheduler: FIFO of written pages presented to the byte reader.
// Optional feature macro: CD_TX_RETRY_EN (re-send aborted frames up to RETRY_MAX times).
module cd_tx_pages_ctrl #(
  parameter int PAGE_NUM = 2,
  parameter int PW = $clog2(PAGE_NUM)
`ifdef CD_TX_RETRY_EN
  , parameter int RETRY_MAX = 3
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_switch,
  input  logic          cpu_flush,
  input  logic [7:0]    gap_len,
  output logic [PW-1:0] cpu_wr_page,
  output logic          has_free,
  output logic          switch_err,
  output logic [PW-1:0] rd_page,
  output logic          ram_unread,
  input  logic          ram_rd_done,
  input  logic          tx_abort,
  output logic          tx_done,
  output logic          tx_fail
);

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

  localparam logic [PW:0] CNT_LAST = (PW+1)'(PAGE_NUM - 1);

  state_t        state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   cnt;
  logic [7:0]    gap_cnt;
  logic          abort_seen;

  logic          sw_ok;
  logic          frame_end;
  logic          aborted;
  logic          retry;
  logic          free;
  logic [7:0]    gap_load;

  assign cpu_wr_page = wr_ptr;
  assign rd_page     = rd_ptr;
  assign has_free    = (cnt < CNT_LAST);

  assign sw_ok     = cpu_switch & has_free & ~cpu_flush;
  assign frame_end = (state == ACTIVE) & ram_rd_done & ~cpu_flush;
  // An abort in the very cycle of ram_rd_done still counts against the frame.
  assign aborted   = abort_seen | tx_abort;
  assign free      = frame_end & ~retry;
  assign gap_load  = (gap_len == 8'd0) ? 8'd1 : gap_len;

`ifdef CD_TX_RETRY_EN
  localparam int RW = $clog2(RETRY_MAX + 1);

  logic [RW-1:0] retry_cnt;

  assign retry = aborted & (retry_cnt < RW'(RETRY_MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retry_cnt <= '0;
    end else if (cpu_flush) begin
      retry_cnt <= '0;
    end else if (frame_end) begin
      retry_cnt <= retry ? retry_cnt + RW'(1) : '0;
    end
  end
`else
  assign retry = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      gap_cnt    <= '0;
      abort_seen <= 1'b0;
      ram_unread <= 1'b0;
      switch_err <= 1'b0;
      tx_done    <= 1'b0;
      tx_fail    <= 1'b0;
    end else begin
      switch_err <= cpu_switch & ~has_free & ~cpu_flush;
      tx_done    <= frame_end & ~aborted;
      tx_fail    <= free & aborted;
      if (sw_ok)
        wr_ptr <= wr_ptr + PW'(1);
      if (cpu_flush) begin
        rd_ptr     <= wr_ptr;
        cnt        <= '0;
        ram_unread <= 1'b0;
        abort_seen <= 1'b0;
        gap_cnt    <= gap_load;
        state      <= (state == ACTIVE) ? GAP : IDLE;
      end else begin
        if (free)
          rd_ptr <= rd_ptr + PW'(1);
        cnt <= cnt + (PW+1)'(sw_ok) - (PW+1)'(free);
        case (state)
          IDLE: begin
            if (cnt != '0 || sw_ok) begin
              state      <= ACTIVE;
              ram_unread <= 1'b1;
            end
          end
          ACTIVE: begin
            if (tx_abort)
              abort_seen <= 1'b1;
            if (ram_rd_done) begin
              ram_unread <= 1'b0;
              abort_seen <= 1'b0;
              gap_cnt    <= gap_load;
              state      <= GAP;
            end
          end
          GAP: begin
            gap_cnt <= gap_cnt - 8'd1;
            if (gap_cnt <= 8'd1)
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cd_tx_pages_ctrl.sv
// tb/tb_cd_tx_pages_ctrl.sv - directed bench for cd_tx_pages_ctrl with a page-order scoreboard.
module tb_cd_tx_pages_ctrl;

  localparam int PN = 4;
  localparam int PW = 2;
`ifdef CD_TX_RETRY_EN
  localparam int RETRIES = 3;
`else
  localparam int RETRIES = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_switch;
  logic          cpu_flush;
  logic [7:0]    gap_len;
  logic [PW-1:0] cpu_wr_page;
  logic          has_free;
  logic          switch_err;
  logic [PW-1:0] rd_page;
  logic          ram_unread;
  logic          ram_rd_done;
  logic          tx_abort;
  logic          tx_done;
  logic          tx_fail;

  int            total = 0;
  int            passed = 0;
  logic [PW-1:0] sb[$];
  logic [PW-1:0] mwr = '0;
  int            mcnt = 0;
  int            low;

  always #5 clk = ~clk;

  cd_tx_pages_ctrl #(.PAGE_NUM(PN), .PW(PW)) dut (
    .clk(clk), .reset(reset),
    .cpu_switch(cpu_switch), .cpu_flush(cpu_flush), .gap_len(gap_len),
    .cpu_wr_page(cpu_wr_page), .has_free(has_free), .switch_err(switch_err),
    .rd_page(rd_page), .ram_unread(ram_unread),
    .ram_rd_done(ram_rd_done), .tx_abort(tx_abort),
    .tx_done(tx_done), .tx_fail(tx_fail)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_switch(input string tag);
    bit ok;
    ok = (mcnt < PN - 1);
    cpu_switch = 1'b1;
    tick();
    cpu_switch = 1'b0;
    chk({tag, "_err"}, switch_err, !ok);
    if (ok) begin
      sb.push_back(mwr);
      mwr++;
      mcnt++;
    end
    chk({tag, "_wr"}, cpu_wr_page, mwr);
    chk({tag, "_free"}, has_free, mcnt < PN - 1);
  endtask

  task automatic wait_start(input string tag, output int low_cycles);
    low_cycles = 0;
    while (!ram_unread && low_cycles < 200) begin
      low_cycles++;
      tick();
    end
    chk({tag, "_start"}, ram_unread, 1);
  endtask

  // Byte reader model: holds the frame for len cycles, then reports its end.
  task automatic do_frame(input string tag, input int len, input bit ab_mid, input bit ab_end,
                          input bit sw_end, input bit exp_fail, input bit exp_free);
    bit ok;
    chk({tag, "_page"}, rd_page, sb[0]);
    for (int i = 1; i < len; i++) begin
      tx_abort = ab_mid && (i == 1);
      tick();
      tx_abort = 1'b0;
    end
    chk({tag, "_stable"}, rd_page, sb[0]);
    ok = (mcnt < PN - 1);
    ram_rd_done = 1'b1;
    tx_abort    = ab_end;
    cpu_switch  = sw_end;
    tick();
    ram_rd_done = 1'b0;
    tx_abort    = 1'b0;
    cpu_switch  = 1'b0;
    if (exp_free) begin
      void'(sb.pop_front());
      mcnt--;
    end
    if (sw_end && ok) begin
      sb.push_back(mwr);
      mwr++;
      mcnt++;
    end
    chk({tag, "_unread"}, ram_unread, 0);
    chk({tag, "_done"}, tx_done, exp_free && !exp_fail);
    chk({tag, "_fail"}, tx_fail, exp_fail);
    chk({tag, "_free"}, has_free, mcnt < PN - 1);
  endtask

  initial begin
    reset = 1'b1;
    cpu_switch = 1'b0;
    cpu_flush = 1'b0;
    gap_len = 8'd0;
    ram_rd_done = 1'b0;
    tx_abort = 1'b0;
    repeat (3) tick();
    chk("rst_wr", cpu_wr_page, 0);
    chk("rst_rd", rd_page, 0);
    chk("rst_unread", ram_unread, 0);
    chk("rst_free", has_free, 1);
    chk("rst_done", tx_done, 0);
    chk("rst_fail", tx_fail, 0);
    chk("rst_err", switch_err, 0);
    reset = 1'b0;
    tick();

    // single frame, gap_len 0, start latency of one cycle
    do_switch("sw0");
    chk("lat", ram_unread, 1);
    do_frame("f0", 5, 0, 0, 0, 0, 1);
    chk("f0_rd", rd_page, 1);

    // fill the queue, overflow, drain in order with gap checks
    gap_len = 8'd3;
    do_switch("sw1");
    do_switch("sw2");
    do_switch("sw3");
    chk("full", has_free, 0);
    do_switch("sw_ovf");
    for (int f = 0; f < 3; f++) begin
      wait_start("q", low);
      if (f > 0)
        chk("q_gap", low, 32'(gap_len) + 1);
      do_frame("q", 3, 0, 0, 0, 0, 1);
    end

    // mid-frame abort on every attempt
    gap_len = 8'd1;
    do_switch("sw_ab");
    for (int a = 0; a <= RETRIES; a++) begin
      wait_start("ab", low);
      do_frame("ab", 4, 1, 0, 0, a == RETRIES, a == RETRIES);
    end

    // abort coincident with ram_rd_done
    gap_len = 8'd0;
    do_switch("sw_abe");
    for (int a = 0; a <= RETRIES; a++) begin
      wait_start("abe", low);
      do_frame("abe", 3, 0, 1, 0, a == RETRIES, a == RETRIES);
    end

    // flush mid-frame with two pages queued
    do_switch("sw_fl0");
    do_switch("sw_fl1");
    wait_start("fl", low);
    tick();
    tick();
    cpu_flush = 1'b1;
    tick();
    cpu_flush = 1'b0;
    sb.delete();
    mcnt = 0;
    chk("fl_unread", ram_unread, 0);
    chk("fl_done", tx_done, 0);
    chk("fl_fail", tx_fail, 0);
    chk("fl_free", has_free, 1);
    chk("fl_rd", rd_page, mwr);
    repeat (10) tick();
    chk("fl_idle", ram_unread, 0);

    // flush beats a simultaneous switch, silently
    cpu_flush = 1'b1;
    cpu_switch = 1'b1;
    tick();
    cpu_flush = 1'b0;
    cpu_switch = 1'b0;
    chk("flsw_err", switch_err, 0);
    chk("flsw_wr", cpu_wr_page, mwr);

    // restart after flush, then switch coincident with the free of the last page
    do_switch("sw_rs");
    wait_start("rs", low);
    do_frame("rs", 3, 0, 0, 1, 0, 1);
    chk("rs_wr", cpu_wr_page, mwr);
    wait_start("rs2", low);
    chk("rs2_gap", low, 2);
    do_frame("rs2", 2, 0, 0, 0, 0, 1);

    // stray ram_rd_done outside ACTIVE
    ram_rd_done = 1'b1;
    tick();
    ram_rd_done = 1'b0;
    chk("stray_done", tx_done, 0);
    chk("stray_fail", tx_fail, 0);
    chk("stray_rd", rd_page, mwr);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cd_tx_pages_ctrl.md
# cd_tx_pages_ctrl

Page scheduler for the CDBUS transmit RAM. It owns PAGE_NUM transmit pages and hands one of them to the CPU for writing. Finished pages are queued in FIFO order, and the controller presents them one at a time to the byte reader through `ram_unread` and `rd_page`. It frees a page on successful completion and, optionally, re-sends aborted frames. It sits between the CPU register file and the tx byte reader / tx RAM address mux.

## Interface
- PAGE_NUM, 2, number of tx pages; power of two, 2..8.
- PW, 1, page index width, $clog2(PAGE_NUM).
- RETRY_MAX, 3, maximum re-sends of one aborted frame (used only with CD_TX_RETRY_EN).

Ports (clk, reset first):
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- cpu_switch  input  1  1-cycle pulse: CPU finished writing `cpu_wr_page`; enqueue it.
- cpu_flush  input  1  1-cycle pulse: drop all queued and active frames.
- gap_len  input  8  idle cycles inserted after each frame; 0 is treated as 1.
- cpu_wr_page  output  PW  page currently owned by the CPU for writing.
- has_free  output  1  a switch will be accepted (queued < PAGE_NUM-1).
- switch_err  output  1  1-cycle pulse: `cpu_switch` arrived while `has_free` was 0; the switch was ignored.
- rd_page  output  PW  page presented to the byte reader (upper tx RAM address bits).
- ram_unread  output  1  frame available to the byte reader; held high for the whole frame.
- ram_rd_done  input  1  1-cycle pulse from the byte reader: frame ended (last byte acked, or abort).
- tx_abort  input  1  abort pulse, the same signal that drives the byte reader's abort input.
- tx_done  output  1  1-cycle pulse: frame sent without abort; its page is freed.
- tx_fail  output  1  1-cycle pulse: aborted frame dropped; its page is freed.

## Operation
- Queue: wr_ptr, rd_ptr (PW bits, wrap modulo PAGE_NUM) and cnt (0..PAGE_NUM-1).
  - `cpu_wr_page` = wr_ptr. `rd_page` = rd_ptr.
  - Accepted `cpu_switch`: wr_ptr+1, cnt+1.
  - Page freed (tx_done or tx_fail): rd_ptr+1, cnt-1.
  - Switch and free in the same cycle: cnt unchanged, both pointers advance.
- FSM states: IDLE, ACTIVE, GAP.
  - IDLE: if cnt>0 (including a switch accepted this cycle), go to ACTIVE and set ram_unread=1.
  - ACTIVE: tx_abort sets abort_seen. On ram_rd_done, clear ram_unread and go to GAP, loading gap_cnt = max(gap_len,1).
    - abort_seen clear and no tx_abort this cycle: tx_done, free page.
    - Otherwise (aborted): tx_fail or retry per Configuration.
    - abort_seen clears on entry to GAP.
  - GAP: gap_cnt decrements to 0, then go to IDLE. tx_abort is ignored in IDLE and GAP.
- cpu_flush, any state:
  - rd_ptr=wr_ptr, cnt=0, retry count cleared, ram_unread=0 next cycle.
  - If the FSM was ACTIVE it goes to GAP; otherwise it goes to IDLE.
  - No tx_done or tx_fail is issued for the flushed frame.
  - Flush wins over a simultaneous cpu_switch, which is discarded without switch_err.
  - Flush wins over a simultaneous ram_rd_done.
- A ram_rd_done arriving outside ACTIVE is ignored.

## Timing
- Reset values:
  - cpu_wr_page=0, rd_page=0, ram_unread=0, has_free=1.
  - switch_err=0, tx_done=0, tx_fail=0.
  - FSM=IDLE, cnt=0, retry count 0.
- All outputs are registered except cpu_wr_page, rd_page and has_free, which decode directly from registers.
- Start latency: switch at cycle N in IDLE gives ram_unread=1 at N+1.
- End of frame: ram_rd_done at cycle M gives ram_unread=0, tx_done/tx_fail pulse and pointer update at M+1.
  - The next frame's ram_unread rises at M+1+max(gap_len,1)+1 at the earliest.
- ram_unread is low for at least 2 cycles between frames; this guarantees the byte reader resets its counters.
- rd_page is stable whenever ram_unread=1. During a retry rd_page does not change.
- has_free updates in the cycle after the switch or free.

## Configuration
- CD_TX_RETRY_EN defined: an aborted frame is re-sent if its retry count < RETRY_MAX.
  - Retry: the retry count increments, the page is not freed, and no pulse is issued. After GAP the same rd_page is presented again.
  - At RETRY_MAX: tx_fail, page freed, retry count cleared.
  - The retry count is also cleared on tx_done.
- CD_TX_RETRY_EN undefined: every aborted frame gives tx_fail and frees its page immediately. RETRY_MAX and the retry counter are not implemented.

## Test plan
- Reset, switch once, gap_len=0, byte reader model acks a 5-byte frame -> ram_unread at +1, rd_page=0; tx_done 1 cycle after ram_rd_done; cpu_wr_page=1, rd_page=1.
- PAGE_NUM=4: three switches back-to-back -> has_free=0; a 4th switch -> switch_err pulse, cnt stays 3; frames sent in order with rd_page 0,1,2 and each gap ≥ gap_len+1.
- Retry enabled, RETRY_MAX=3: abort every attempt -> 4 transmissions of page 0, then one tx_fail; no tx_done.
- Retry disabled: tx_abort in the same cycle as ram_rd_done -> tx_fail (not tx_done), page freed.
- cpu_flush mid-frame with 2 pages queued -> ram_unread=0 next cycle, cnt=0, no pulses; a later switch restarts from rd_page=wr_ptr.
- cpu_switch in the same cycle as the free of the last queued page (cnt=1, PAGE_NUM=2) -> cnt stays 1, new frame starts after the gap.
